// File: rtl/multi_channel_valid_credit.sv
// Multi-channel valid/credit link: round-robin arbitration onto one forward pipe,
// per-channel receive FIFOs, and a credit-return pipe that bounds outstanding words.
module multi_channel_valid_credit #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int VALID_FFS  = 3,
  parameter int CREDIT_FFS = 2,
  localparam int CH_DEPTH  = VALID_FFS + CREDIT_FFS + 2,
  localparam int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W     = $clog2(CH_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [NUM_CH-1:0]            out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*CNT_W-1:0]      credit_cnt
);

  localparam int PTR_W = $clog2(CH_DEPTH);

  logic [CNT_W-1:0]      cnt [NUM_CH];
  logic [ID_W-1:0]       rr_ptr;
  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     grant;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       idx;
  logic [DATA_WIDTH-1:0] grant_data;

  logic [VALID_FFS-1:0]  vld_p;
  logic [ID_W-1:0]       id_p   [VALID_FFS];
  logic [DATA_WIDTH-1:0] data_p [VALID_FFS];

  logic [NUM_CH-1:0]     crd_p  [CREDIT_FFS];
  logic [NUM_CH-1:0]     crd_ret;

  logic [PTR_W-1:0]      wr_ptr [NUM_CH];
  logic [PTR_W-1:0]      rd_ptr [NUM_CH];
  logic [CNT_W-1:0]      fill   [NUM_CH];
  logic [DATA_WIDTH-1:0] mem    [NUM_CH][CH_DEPTH];
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CH_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++)
      eligible[i] = in_valid[i] && (cnt[i] < CNT_W'(CH_DEPTH)) && !reset;
  end

  // Round-robin: search begins one past the last granted channel.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_CH);
      if (grant == '0 && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_ready = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rr_ptr <= ID_W'(NUM_CH - 1);
    else if (|grant) rr_ptr <= grant_id;
  end

  // Forward pipe p0..p(VALID_FFS-1): advances every cycle, no stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int s = 0; s < VALID_FFS; s++) begin
        id_p[s]   <= '0;
        data_p[s] <= '0;
      end
    end else begin
      vld_p[0]  <= |grant;
      id_p[0]   <= grant_id;
      data_p[0] <= grant_data;
      for (int s = 1; s < VALID_FFS; s++) begin
        vld_p[s]  <= vld_p[s-1];
        id_p[s]   <= id_p[s-1];
        data_p[s] <= data_p[s-1];
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i] = vld_p[VALID_FFS-1] && (id_p[VALID_FFS-1] == ID_W'(i));
      pop[i]  = out_valid[i] && out_ready[i];
    end
  end

  // Per-channel receive FIFOs fed from the last forward stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= next_ptr(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= next_ptr(rd_ptr[i]);
        if (push[i] && !pop[i])      fill[i] <= fill[i] + 1'b1;
        else if (!push[i] && pop[i]) fill[i] <= fill[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= data_p[VALID_FFS-1];
  end

  always_comb begin
    out_valid  = '0;
    out_data   = '0;
    credit_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_valid[i]                      = (fill[i] != '0);
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
      credit_cnt[i*CNT_W +: CNT_W]      = cnt[i];
    end
  end

  // Credit-return pipe: one bit per channel, several may return together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < CREDIT_FFS; s++) crd_p[s] <= '0;
    end else begin
      crd_p[0] <= pop;
      for (int s = 1; s < CREDIT_FFS; s++) crd_p[s] <= crd_p[s-1];
    end
  end

  assign crd_ret = crd_p[CREDIT_FFS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i] && !crd_ret[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!grant[i] && crd_ret[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        assert (!(crd_ret[i] && cnt[i] == '0))
          else $error("credit returned on channel %0d with no outstanding words", i);
        assert (!(push[i] && fill[i] == CNT_W'(CH_DEPTH)))
          else $error("write into full FIFO on channel %0d", i);
      end
    end
  end

endmodule
